// File: rtl/led_sequencer.sv
// ============================================================================
// Module   : led_sequencer
// Purpose  : Drives NUM_LEDS board LEDs with a selectable pattern (binary
//            count, rotate, bounce, blink). A programmable prescaler sets how
//            fast the pattern advances. The block also exports a one-cycle
//            step pulse for other status logic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_LEDS : number of LED outputs (1..32)
//   DIV_W    : width of the prescaler divisor and counter
// Ports:
//   clk      in   1         system clock, all logic on posedge
//   resetn   in   1         asynchronous active-low reset
//   enable   in   1         1 = prescaler runs and pattern advances
//   mode     in   2         0 count, 1 rotate, 2 bounce, 3 blink
//   div      in   DIV_W     step period minus one, in clk cycles
//   bright   in   8         PWM brightness (only with LED_SEQ_PWM_EN)
//   led      out  NUM_LEDS  registered LED pattern
//   step     out  1         registered one-cycle pulse per pattern advance
// Build option:
//   LED_SEQ_PWM_EN : adds the bright port and an 8-bit PWM dimmer on led.
//                    This adds one cycle of led latency relative to step.
// ============================================================================
`default_nettype none

module led_sequencer #(
   parameter int NUM_LEDS = 4,
   parameter int DIV_W    = 24
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [DIV_W-1:0]    div,
`ifdef LED_SEQ_PWM_EN
   input  logic [7:0]          bright,
`endif
   output logic [NUM_LEDS-1:0] led,
   output logic                step
);

   localparam logic [1:0] MODE_COUNT  = 2'd0;
   localparam logic [1:0] MODE_ROTATE = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_BLINK  = 2'd3;

   // Bounce direction state machine
   typedef enum logic [0:0] {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [DIV_W-1:0]    cnt, cnt_next;
   logic [NUM_LEDS-1:0] pattern, pattern_next;
   dir_t                dir, dir_next;
   logic [1:0]          mode_q;
   logic                step_q, step_next;

   logic                tick;
   logic                reload;
   logic [NUM_LEDS-1:0] seed;
   logic [NUM_LEDS-1:0] rotate_next;
   logic [NUM_LEDS-1:0] bounce_up_next;
   logic [NUM_LEDS-1:0] bounce_down_next;
   logic                top_hit;
   logic                bottom_hit;

   // Greater-or-equal makes a divisor lowered mid-count fire on the next
   // enabled cycle instead of waiting for the counter to wrap.
   assign tick   = enable && (cnt >= div);
   assign reload = (mode != mode_q);

   // Shift helpers. With a single LED, rotate and bounce have nowhere to go,
   // so they hold and the direction never flips.
   generate
      if (NUM_LEDS > 1) begin : g_multi
         assign rotate_next      = {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
         assign bounce_up_next   = pattern << 1;
         assign bounce_down_next = pattern >> 1;
         // Flip on the same update that lands the one-hot on an end bit, so
         // each end bit is shown for exactly one step.
         assign top_hit          = pattern[NUM_LEDS-2];
         assign bottom_hit       = pattern[1];
      end else begin : g_single
         assign rotate_next      = pattern;
         assign bounce_up_next   = pattern;
         assign bounce_down_next = pattern;
         assign top_hit          = 1'b0;
         assign bottom_hit       = 1'b0;
      end
   endgenerate

   // Seed loaded whenever the mode changes
   always_comb begin
      seed = '0;
      case (mode)
         MODE_ROTATE: seed = NUM_LEDS'(1);
         MODE_BOUNCE: seed = NUM_LEDS'(1);
         default:     seed = '0;
      endcase
   end

   // Next-state logic. A mode reload overrides everything, including a tick
   // and the enable hold.
   always_comb begin
      cnt_next     = cnt;
      pattern_next = pattern;
      dir_next     = dir;
      step_next    = 1'b0;

      if (reload) begin
         pattern_next = seed;
         cnt_next     = '0;
         dir_next     = DIR_UP;
      end else if (tick) begin
         cnt_next  = '0;
         step_next = 1'b1;
         case (mode_q)
            MODE_COUNT:  pattern_next = pattern + NUM_LEDS'(1);
            MODE_ROTATE: pattern_next = rotate_next;
            MODE_BOUNCE: begin
               if (dir == DIR_UP) begin
                  pattern_next = bounce_up_next;
                  if (top_hit) begin
                     dir_next = DIR_DOWN;
                  end
               end else begin
                  pattern_next = bounce_down_next;
                  if (bottom_hit) begin
                     dir_next = DIR_UP;
                  end
               end
            end
            MODE_BLINK:  pattern_next = ~pattern;
            default:     pattern_next = pattern;
         endcase
      end else if (enable) begin
         cnt_next = cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         pattern <= '0;
         dir     <= DIR_UP;
         mode_q  <= MODE_COUNT;
         step_q  <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         pattern <= pattern_next;
         dir     <= dir_next;
         mode_q  <= mode;
         step_q  <= step_next;
      end
   end

   assign step = step_q;

`ifdef LED_SEQ_PWM_EN
   logic [7:0]          pwm_cnt;
   logic [NUM_LEDS-1:0] led_q;

   // Free-running PWM; bright = 0 is fully off, 255 gives 255/256 duty.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pwm_cnt <= '0;
         led_q   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         led_q   <= pattern & {NUM_LEDS{(pwm_cnt < bright)}};
      end
   end

   assign led = led_q;
`else
   assign led = pattern;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// Module   : tb_led_sequencer
// Purpose  : Self-checking bench for led_sequencer (NUM_LEDS = 4, default
//            build). A table of per-cycle vectors covers count wrap, bounce,
//            rotate-to-blink mode switching. Hand-written sequences cover a
//            divisor lowered mid-count, an enable freeze, and an asynchronous
//            reset during bounce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_sequencer;

   localparam int NUM_LEDS = 4;
   localparam int DIV_W    = 24;

   logic                clk;
   logic                resetn;
   logic                enable;
   logic [1:0]          mode;
   logic [DIV_W-1:0]    div;
   logic [NUM_LEDS-1:0] led;
   logic                step;

   int n_vec;
   int n_bad;

   typedef struct {
      logic                en;
      logic [1:0]          md;
      logic [DIV_W-1:0]    dv;
      logic [NUM_LEDS-1:0] exp_led;
      logic                exp_step;
   } vec_t;

   vec_t vecs[$];

   led_sequencer #(
      .NUM_LEDS (NUM_LEDS),
      .DIV_W    (DIV_W)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .enable (enable),
      .mode   (mode),
      .div    (div),
      .led    (led),
      .step   (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add_vec(input logic en, input logic [1:0] md, input int dv,
                          input int exp_led, input logic exp_step);
      vec_t v;
      v.en       = en;
      v.md       = md;
      v.dv       = DIV_W'(dv);
      v.exp_led  = NUM_LEDS'(exp_led);
      v.exp_step = exp_step;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [NUM_LEDS-1:0] exp_led, input logic exp_step);
      n_vec++;
      if (led !== exp_led || step !== exp_step) begin
         n_bad++;
         $display("FAIL %s[%0d]: got led=%h step=%b, expected led=%h step=%b",
                  name, idx, led, step, exp_led, exp_step);
      end
   endtask

   // Advance one clock and sample just after the edge
   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycle(input string name, input int idx,
                            input logic [NUM_LEDS-1:0] exp_led, input logic exp_step);
      tick_clk();
      check(name, idx, exp_led, exp_step);
   endtask

   initial begin
      n_vec  = 0;
      n_bad  = 0;
      resetn = 1'b0;
      enable = 1'b0;
      mode   = 2'd0;
      div    = DIV_W'(2);

      // ---- vector table ----
      // Count, div=2: a step every 3rd edge, led 0..15 then wraps to 0.
      for (int i = 1; i <= 48; i++) begin
         add_vec(1'b1, 2'd0, 2, (i / 3) % 16, (i % 3) == 0);
      end
      // Bounce, div=0: reload edge shows seed, then one step per edge.
      add_vec(1'b1, 2'd2, 0, 4'h1, 1'b0);
      add_vec(1'b1, 2'd2, 0, 4'h2, 1'b1);
      add_vec(1'b1, 2'd2, 0, 4'h4, 1'b1);
      add_vec(1'b1, 2'd2, 0, 4'h8, 1'b1);
      add_vec(1'b1, 2'd2, 0, 4'h4, 1'b1);
      add_vec(1'b1, 2'd2, 0, 4'h2, 1'b1);
      add_vec(1'b1, 2'd2, 0, 4'h1, 1'b1);
      add_vec(1'b1, 2'd2, 0, 4'h2, 1'b1);
      // Rotate, div=0: up to led=8
      add_vec(1'b1, 2'd1, 0, 4'h1, 1'b0);
      add_vec(1'b1, 2'd1, 0, 4'h2, 1'b1);
      add_vec(1'b1, 2'd1, 0, 4'h4, 1'b1);
      add_vec(1'b1, 2'd1, 0, 4'h8, 1'b1);
      // Blink, div=3: reload to 0 with no step, F after 4 edges, 0 after 4 more
      add_vec(1'b1, 2'd3, 3, 4'h0, 1'b0);
      add_vec(1'b1, 2'd3, 3, 4'h0, 1'b0);
      add_vec(1'b1, 2'd3, 3, 4'h0, 1'b0);
      add_vec(1'b1, 2'd3, 3, 4'h0, 1'b0);
      add_vec(1'b1, 2'd3, 3, 4'hF, 1'b1);
      add_vec(1'b1, 2'd3, 3, 4'hF, 1'b0);
      add_vec(1'b1, 2'd3, 3, 4'hF, 1'b0);
      add_vec(1'b1, 2'd3, 3, 4'hF, 1'b0);
      add_vec(1'b1, 2'd3, 3, 4'h0, 1'b1);

      // ---- reset state ----
      #12;
      check("reset", 0, 4'h0, 1'b0);
      tick_clk();
      check("reset", 1, 4'h0, 1'b0);
      resetn = 1'b1;

      // ---- table ----
      foreach (vecs[i]) begin
         enable = vecs[i].en;
         mode   = vecs[i].md;
         div    = vecs[i].dv;
         run_cycle("vec", i, vecs[i].exp_led, vecs[i].exp_step);
      end

      // ---- divisor lowered mid-count ----
      mode = 2'd0;
      div  = DIV_W'(100);
      run_cycle("div_reload", 0, 4'h0, 1'b0);
      for (int i = 1; i <= 50; i++) begin
         run_cycle("div_slow", i, 4'h0, 1'b0);
      end
      div = DIV_W'(10);
      run_cycle("div_lowered", 0, 4'h1, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         run_cycle("div_period", i, 4'h1, 1'b0);
      end
      run_cycle("div_period", 11, 4'h2, 1'b1);

      // ---- enable freeze mid-count (cnt reaches 4 first) ----
      for (int i = 0; i < 4; i++) begin
         run_cycle("pre_freeze", i, 4'h2, 1'b0);
      end
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         run_cycle("freeze", i, 4'h2, 1'b0);
      end
      enable = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         run_cycle("resume", i, 4'h2, 1'b0);
      end
      run_cycle("resume", 7, 4'h3, 1'b1);

      // ---- async reset during bounce DOWN ----
      mode = 2'd2;
      div  = DIV_W'(0);
      run_cycle("bnc", 0, 4'h1, 1'b0);
      run_cycle("bnc", 1, 4'h2, 1'b1);
      run_cycle("bnc", 2, 4'h4, 1'b1);
      run_cycle("bnc", 3, 4'h8, 1'b1);
      run_cycle("bnc", 4, 4'h4, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst", 0, 4'h0, 1'b0);
      tick_clk();
      check("async_rst", 1, 4'h0, 1'b0);
      #2;
      resetn = 1'b1;
      run_cycle("post_rst", 0, 4'h1, 1'b0);
      run_cycle("post_rst", 1, 4'h2, 1'b1);
      run_cycle("post_rst", 2, 4'h4, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
